// File: rtl/seven_seg_scan_ctrl.sv
// Purpose : 4-digit seven-segment scan controller with blanking gaps and frame-aligned double buffering.
// Latency : registered outputs; en=1 in OFF -> digit 0 lit BLANK_CYCLES+1 edges later; load visible after the next frame end or start.
// Backpr. : none; load is a fire-and-forget strobe, and the last load before a frame boundary wins.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   en                    scan enable (0 = dark, scan parked at digit 0)
//   load                  strobe capturing value/digit_mask/lzb into the pending buffer
//   value[15:0]           nibble i = digit i code, digit 3 most significant
//   digit_mask[3:0]       per-digit visibility
//   lzb                   leading-zero blanking request
//   dec_en, dec_num[3:0]  decoder enable and digit code
//   anode[3:0]            one-hot active-high digit select
//   digit_idx[1:0]        digit currently scheduled
//   frame_done            one-cycle pulse after digit 3 finishes its SHOW
module seven_seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  digit_mask,
  input  logic        lzb,
  output logic        dec_en,
  output logic [3:0]  dec_num,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic [15:0]   r_act_val;
  logic [3:0]    r_act_mask;
  logic          r_act_lzb;
  logic [15:0]   r_pend_val;
  logic [3:0]    r_pend_mask;
  logic          r_pend_lzb;
  logic          r_pend_vld;

  logic          r_dec_en;
  logic [3:0]    r_dec_num;
  logic [3:0]    r_anode;
  logic          r_frame_done;

  // Leading-zero blanking: digit i goes dark when it and every higher nibble
  // are zero. Digit 0 is exempt so a zero value still shows "0".
  logic [3:0]    w_blank_lz;
  logic [3:0]    w_vis;
  logic [3:0]    w_nib;

  assign w_blank_lz[3] = r_act_lzb && (r_act_val[15:12] == 4'd0);
  assign w_blank_lz[2] = w_blank_lz[3] && (r_act_val[11:8] == 4'd0);
  assign w_blank_lz[1] = w_blank_lz[2] && (r_act_val[7:4] == 4'd0);
  assign w_blank_lz[0] = 1'b0;
  assign w_vis         = r_act_mask & ~w_blank_lz;
  assign w_nib         = r_act_val[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_act_val    <= 16'd0;
      r_act_mask   <= 4'd0;
      r_act_lzb    <= 1'b0;
      r_pend_val   <= 16'd0;
      r_pend_mask  <= 4'd0;
      r_pend_lzb   <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_dec_en     <= 1'b0;
      r_dec_num    <= 4'd0;
      r_anode      <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // Pending capture happens in every state; the frame-end branch below
      // overrides pending_valid when the load is consumed directly.
      if (load) begin
        r_pend_val  <= value;
        r_pend_mask <= digit_mask;
        r_pend_lzb  <= lzb;
        r_pend_vld  <= 1'b1;
      end

      case (r_state)
        S_OFF: begin
          if (en) begin
            r_state <= S_BLANK;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            if (r_pend_vld) begin
              r_act_val  <= r_pend_val;
              r_act_mask <= r_pend_mask;
              r_act_lzb  <= r_pend_lzb;
            end
            // A load in this very cycle stays pending for the next boundary.
            if (!load) r_pend_vld <= 1'b0;
          end
        end

        S_BLANK: begin
          if (!en) begin
            r_state   <= S_OFF;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_anode   <= 4'd0;
            r_dec_en  <= 1'b0;
            r_dec_num <= 4'd0;
          end else if (r_cnt == BLANK_LAST) begin
            r_state   <= S_SHOW;
            r_cnt     <= '0;
            r_dec_num <= w_nib;
            r_dec_en  <= w_vis[r_idx];
            r_anode   <= w_vis[r_idx] ? (4'b0001 << r_idx) : 4'b0000;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SHOW: begin
          if (!en) begin
            r_state   <= S_OFF;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_anode   <= 4'd0;
            r_dec_en  <= 1'b0;
            r_dec_num <= 4'd0;
          end else if (r_cnt == DWELL_LAST) begin
            r_state   <= S_BLANK;
            r_cnt     <= '0;
            r_idx     <= r_idx + 2'd1;
            r_anode   <= 4'd0;
            r_dec_en  <= 1'b0;
            r_dec_num <= 4'd0;
            if (r_idx == 2'd3) begin
              r_frame_done <= 1'b1;
              // A load coinciding with the frame end bypasses pending.
              if (load) begin
                r_act_val  <= value;
                r_act_mask <= digit_mask;
                r_act_lzb  <= lzb;
              end else if (r_pend_vld) begin
                r_act_val  <= r_pend_val;
                r_act_mask <= r_pend_mask;
                r_act_lzb  <= r_pend_lzb;
              end
              r_pend_vld <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= S_OFF;
          r_idx     <= 2'd0;
          r_cnt     <= '0;
          r_anode   <= 4'd0;
          r_dec_en  <= 1'b0;
          r_dec_num <= 4'd0;
        end
      endcase
    end
  end

  assign dec_en     = r_dec_en;
  assign dec_num    = r_dec_num;
  assign anode      = r_anode;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Purpose : self-checking bench for seven_seg_scan_ctrl against a time-position reference model.
// Latency : every output compared #1 after each rising edge.
// Backpr. : n/a; inputs are driven freely between edges.
module tb_seven_seg_scan_ctrl;

  localparam int D = 4;
  localparam int B = 2;
  localparam int U = B + D;      // per-digit period
  localparam int P = 4 * U;      // frame period

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_mask;
  logic        lzb;
  logic        dec_en;
  logic [3:0]  dec_num;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: scan position is just "cycles since the scan started".
  bit          m_on;
  int          m_t;
  logic [15:0] m_act_val, m_pend_val;
  logic [3:0]  m_act_mask, m_pend_mask;
  logic        m_act_lzb, m_pend_lzb, m_pv, m_fd;

  seven_seg_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .digit_mask (digit_mask),
    .lzb        (lzb),
    .dec_en     (dec_en),
    .dec_num    (dec_num),
    .anode      (anode),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pos();
    return m_t % P;
  endfunction

  task automatic model_edge();
    bit fe, st;
    fe = m_on && en && (m_pos() == P - 1);
    st = !m_on && en;
    if (!rst_n) begin
      m_on = 0; m_t = 0; m_fd = 0; m_pv = 0;
      m_act_val = 0; m_act_mask = 0; m_act_lzb = 0;
      m_pend_val = 0; m_pend_mask = 0; m_pend_lzb = 0;
    end else begin
      if (fe) begin
        if (load) begin
          m_act_val = value; m_act_mask = digit_mask; m_act_lzb = lzb;
        end else if (m_pv) begin
          m_act_val = m_pend_val; m_act_mask = m_pend_mask; m_act_lzb = m_pend_lzb;
        end
        m_pv = 0;
      end else begin
        if (st) begin
          if (m_pv) begin
            m_act_val = m_pend_val; m_act_mask = m_pend_mask; m_act_lzb = m_pend_lzb;
          end
          m_pv = 0;
        end
        if (load) begin
          m_pend_val = value; m_pend_mask = digit_mask; m_pend_lzb = lzb; m_pv = 1;
        end
      end
      m_fd = fe;
      if (!en) begin
        m_on = 0; m_t = 0;
      end else if (st) begin
        m_on = 1; m_t = 0;
      end else if (m_on) begin
        m_t++;
      end
    end
  endtask

  task automatic compare_outputs();
    int  d, w;
    bit  show, vis;
    logic [15:0] rest;
    logic [3:0]  e_an, e_num;
    logic [1:0]  e_idx;
    logic        e_en;
    d = 0; show = 0; vis = 0;
    e_an = 0; e_en = 0; e_num = 0; e_idx = 0;
    if (m_on) begin
      d    = m_pos() / U;
      w    = m_pos() % U;
      show = (w >= B);
      e_idx = 2'(d);
      if (show) begin
        rest  = m_act_val >> (4 * d);
        e_num = rest[3:0];
        vis   = m_act_mask[d] && !(m_act_lzb && d != 0 && rest == 16'd0);
        e_en  = vis;
        e_an  = vis ? 4'(1 << d) : 4'd0;
      end
    end
    chk("anode", 32'(anode), 32'(e_an));
    chk("dec_en", 32'(dec_en), 32'(e_en));
    chk("digit_idx", 32'(digit_idx), 32'(e_idx));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (m_on && show) chk("dec_num", 32'(dec_num), 32'(e_num));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic z);
    value = v; digit_mask = m; lzb = z; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the model sits at a given frame position (bounded).
  task automatic wait_pos(input int pos);
    int k;
    k = 0;
    while (!(m_on && m_pos() == pos) && k < 4 * P) begin
      step();
      k++;
    end
    chk("wait_pos_timeout", 32'(k < 4 * P), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'd0; digit_mask = 4'd0; lzb = 1'b0;
    run(2);
    chk("rst_anode", 32'(anode), 32'd0);
    chk("rst_dec_en", 32'(dec_en), 32'd0);
    chk("rst_dec_num", 32'(dec_num), 32'd0);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Basic scan of 1234, loaded while OFF.
    do_load(16'h1234, 4'hF, 1'b0);
    run(3);
    en = 1'b1;
    step();
    chk("first_blank_anode", 32'(anode), 32'd0);
    run(B);
    chk("first_show_anode", 32'(anode), 32'd1);
    chk("first_show_num", 32'(dec_num), 32'd4);
    run(2 * P);

    // Leading-zero blanking.
    do_load(16'h0070, 4'hF, 1'b1);
    run(2 * P);
    do_load(16'h0000, 4'hF, 1'b1);
    run(2 * P);

    // Mid-frame load during digit 1 SHOW, then two loads in one frame.
    do_load(16'h1234, 4'hF, 1'b0);
    run(2 * P);
    wait_pos(U + B + 1);
    do_load(16'h5555, 4'hF, 1'b0);
    run(2 * P);
    wait_pos(U);
    do_load(16'h1111, 4'hF, 1'b0);
    wait_pos(3 * U);
    do_load(16'h9876, 4'hF, 1'b0);
    run(2 * P);

    // Load coinciding with the frame end.
    wait_pos(P - 1);
    do_load(16'h4321, 4'hB, 1'b0);
    run(P);

    // Disable during digit 2 SHOW, then re-enable.
    wait_pos(2 * U + B + 1);
    en = 1'b0;
    step();
    chk("dis_anode", 32'(anode), 32'd0);
    chk("dis_idx", 32'(digit_idx), 32'd0);
    run(3);
    en = 1'b1;
    run(2 * P);

    // Reset during SHOW together with a load.
    wait_pos(B + 1);
    rst_n = 1'b0;
    value = 16'hABCD; digit_mask = 4'hF; load = 1'b1;
    step();
    load = 1'b0; rst_n = 1'b1; en = 1'b0;
    chk("mrst_anode", 32'(anode), 32'd0);
    chk("mrst_dec_num", 32'(dec_num), 32'd0);
    en = 1'b1;
    run(2 * P);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      en         = ($urandom_range(0, 49) != 0);
      load       = ($urandom_range(0, 9) == 0);
      value      = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      if ($urandom_range(0, 3) == 0) value = value & 16'h000F;
      digit_mask = 4'($urandom);
      lzb        = 1'($urandom);
      step();
    end
    rst_n = 1'b1; en = 1'b1; load = 1'b0;
    run(P);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
